// File: rtl/gb_i2s_dac_tx.sv
// gb_i2s_dac_tx: buffers stereo APU samples and serialises them as I2S
// against codec-driven BCLK/LRCK, all oversampled on the system clock.
module gb_i2s_dac_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         sample_left,
    input  logic [DATA_WIDTH-1:0]         sample_right,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic                          aud_bclk,
    input  logic                          aud_daclrck,
    output logic                          aud_dacdat,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {SYNC_WAIT, LEFT, RIGHT} state_t;

    state_t                    state, state_nxt;
    logic [2:0]                bclk_sync, lr_sync;
    logic                      bclk_fall, lr_fall, lr_rise;
    logic [2*DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [2*DATA_WIDTH-1:0]   fifo_dout;
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [AW:0]               level_nxt;
    logic                      push, pop, fifo_empty;
    logic                      load_l, load_r, shift;
    logic [DATA_WIDTH-1:0]     shreg, hold_r;
    logic [CW-1:0]             bit_cnt;

    // [0],[1] are the two-flop synchroniser, [2] is the previous value for edge detect
    assign bclk_fall = bclk_sync[2] & ~bclk_sync[1];
    assign lr_fall   = lr_sync[2]   & ~lr_sync[1];
    assign lr_rise   = ~lr_sync[2]  &  lr_sync[1];

    assign fifo_empty = (fifo_level == '0);
    assign push       = sample_valid & sample_ready;
    assign pop        = load_l & ~fifo_empty;
    assign fifo_dout  = mem[rd_ptr];
    assign level_nxt  = fifo_level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    // Codec clock synchronisers
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], aud_bclk};
            lr_sync   <= {lr_sync[1:0], aud_daclrck};
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {sample_left, sample_right};
    end

    // FIFO pointers, level and registered ready (looks ahead so a full FIFO never overflows)
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            sample_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_level   <= level_nxt;
            sample_ready <= (level_nxt != (AW+1)'(FIFO_DEPTH));
        end
    end

    // Channel state register
    always_ff @(posedge clk) begin
        if (reset) state <= SYNC_WAIT;
        else       state <= state_nxt;
    end

    // Next state and load/shift strobes; an LR edge suppresses the coincident shift
    always_comb begin
        state_nxt = state;
        load_l    = 1'b0;
        load_r    = 1'b0;
        shift     = 1'b0;
        case (state)
            SYNC_WAIT: begin
                if (lr_fall) begin
                    state_nxt = LEFT;
                    load_l    = 1'b1;
                end
            end
            LEFT: begin
                if (lr_rise) begin
                    state_nxt = RIGHT;
                    load_r    = 1'b1;
                end else begin
                    shift = bclk_fall;
                end
            end
            RIGHT: begin
                if (lr_fall) begin
                    state_nxt = LEFT;
                    load_l    = 1'b1;
                end else begin
                    shift = bclk_fall;
                end
            end
            default: state_nxt = SYNC_WAIT;
        endcase
    end

    // Word load and serialiser; the left word goes straight from the FIFO into
    // the shifter, so only the right word needs holding until mid-frame
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg      <= '0;
            hold_r     <= '0;
            bit_cnt    <= '0;
            aud_dacdat <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (load_l) begin
                bit_cnt <= CW'(DATA_WIDTH);
                if (fifo_empty) begin
                    shreg    <= '0;
                    hold_r   <= '0;
                    underrun <= 1'b1;
                end else begin
                    shreg  <= fifo_dout[2*DATA_WIDTH-1:DATA_WIDTH];
                    hold_r <= fifo_dout[DATA_WIDTH-1:0];
                end
            end else if (load_r) begin
                shreg   <= hold_r;
                bit_cnt <= CW'(DATA_WIDTH);
            end else if (shift) begin
                if (bit_cnt != '0) begin
                    aud_dacdat <= shreg[DATA_WIDTH-1];
                    shreg      <= {shreg[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt    <= bit_cnt - 1'b1;
                end else begin
                    aud_dacdat <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_gb_i2s_dac_tx.sv
// Bench for gb_i2s_dac_tx: codec clock generator with an I2S receiver model
// fed by a scoreboard of accepted sample pairs.
module tb_gb_i2s_dac_tx;
    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] sample_left = '0, sample_right = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          aud_bclk, aud_daclrck;
    logic          aud_dacdat;
    logic [3:0]    fifo_level;
    logic          underrun;

    int n_vec = 0, n_miss = 0;
    logic [2*DW-1:0] sb_q[$];
    bit   gen_en = 0, gen_busy = 0, bench_sync = 0;
    logic last_exp = 1'b0;
    int   half_len = 32, half_cnt = 0, cur_j = 0, under_cnt = 0;

    gb_i2s_dac_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .sample_left(sample_left), .sample_right(sample_right),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck), .aud_dacdat(aud_dacdat),
        .fifo_level(fifo_level), .underrun(underrun)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (underrun === 1'b1) under_cnt <= under_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_vec++;
        n_miss++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    // Offer a pair; on acceptance record it and drop valid, otherwise leave it held
    task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r,
                             input int budget, output bit ok);
        @(negedge clk);
        sample_left = l; sample_right = r; sample_valid = 1'b1; ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (sample_ready) begin
                @(posedge clk);
                ok = 1;
                sb_q.push_back({l, r});
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(negedge clk);
            sample_valid = 1'b0;
        end
    endtask

    task automatic wait_gen(input int hc, input int jj);
        int i;
        for (i = 0; i < 12000; i++) begin
            if (half_cnt == hc && cur_j == jj) break;
            @(negedge clk);
        end
        if (i == 12000) timeout_fail("wait_gen");
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 3000; i++) begin
            if (!gen_busy) break;
            @(negedge clk);
        end
        if (i == 3000) timeout_fail("wait_idle");
    endtask

    // Codec: BCLK = 16 clk, half-frame of half_len BCLKs, LRCK and BCLK fall together.
    // Data is sampled on the BCLK rise, i.e. the bit produced by the preceding fall.
    initial begin : codec
        logic [2*DW-1:0] p;
        logic [DW-1:0]   word, rword;
        int n, u0, eu;
        aud_bclk = 1'b1; aud_daclrck = 1'b1;
        word = '0; rword = '0;
        forever begin
            @(negedge clk);
            if (gen_en) begin
                gen_busy = 1; n = half_len;
                for (int h = 0; h < 2; h++) begin
                    eu = 0;
                    if (h == 0) begin
                        bench_sync = 0;
                        if (sb_q.size() > 0) p = sb_q.pop_front();
                        else begin p = '0; eu = 1; end
                        word = p[2*DW-1:DW]; rword = p[DW-1:0];
                    end else begin
                        word = bench_sync ? '0 : rword;
                    end
                    u0 = under_cnt; half_cnt++;
                    for (int j = 0; j < n; j++) begin
                        cur_j = j; aud_bclk = 1'b0;
                        if (j == 0) aud_daclrck = (h == 1);
                        repeat (8) @(negedge clk);
                        aud_bclk = 1'b1;
                        if (j == 0) begin
                            check("underrun_pulses", under_cnt - u0, eu);
                            check("lr_edge_hold", aud_dacdat, last_exp);
                        end else begin
                            if (bench_sync || j > DW) last_exp = 1'b0;
                            else last_exp = word[DW-j];
                            if (h == 0) check("left_bit", aud_dacdat, last_exp);
                            else        check("right_bit", aud_dacdat, last_exp);
                        end
                        repeat (8) @(negedge clk);
                    end
                end
                gen_busy = 0;
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit ok;
        int acc, hc, i;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", sample_ready, 0);
        check("rst_dacdat", aud_dacdat, 0);
        check("rst_level", fifo_level, 0);
        check("rst_underrun", underrun, 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", sample_ready, 1);

        // Basic frame, 64-BCLK frames
        push_pair(16'hA5C3, 16'h0F0F, 20, ok);
        check("basic_accept", ok, 1);
        check("basic_level1", fifo_level, 1);
        gen_en = 1;
        wait_gen(half_cnt + 1, 1);
        check("basic_level0", fifo_level, 0);
        gen_en = 0;
        wait_idle();

        // Fill with no LR edges: 8 accepted, 9th held
        acc = 0;
        for (int k = 0; k < 9; k++) begin
            push_pair(16'h1000 + 16'(k), 16'h2000 + 16'(k), 20, ok);
            if (ok) acc++;
        end
        check("fill_count", acc, 8);
        check("fill_level", fifo_level, 8);
        check("fill_ready", sample_ready, 0);

        // Pop at lr_fall with the 9th pair still offered: refused that cycle, accepted after
        gen_en = 1;
        for (i = 0; i < 2000; i++) begin
            if (sample_ready) break;
            @(negedge clk);
        end
        if (i == 2000) timeout_fail("ready_return");
        check("pop_ready", sample_ready, 1);
        check("pop_level7", fifo_level, 7);
        hc = half_cnt;
        @(posedge clk);
        sb_q.push_back({16'h1008, 16'h2008});
        @(negedge clk);
        sample_valid = 1'b0;
        check("refill_level8", fifo_level, 8);

        // Drain 8 more frames, then an underrun frame
        wait_gen(hc + 18, 2);
        check("underrun_level", fifo_level, 0);
        gen_en = 0;
        wait_idle();
        check("underrun_level_end", fifo_level, 0);

        // Reset at bit 5 of a left word
        push_pair(16'h1234, 16'h5678, 20, ok);
        push_pair(16'h9ABC, 16'hDEF0, 20, ok);
        check("mid_level2", fifo_level, 2);
        hc = half_cnt + 1;
        gen_en = 1;
        wait_gen(hc, 5);
        repeat (6) @(negedge clk);
        reset = 1'b1; bench_sync = 1; last_exp = 1'b0; sb_q.delete();
        @(negedge clk);
        check("mid_rst_dacdat", aud_dacdat, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_ready", sample_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_dacdat_after", aud_dacdat, 0);
        check("mid_rst_ready_after", sample_ready, 1);
        push_pair(16'h3C3C, 16'hC3C3, 20, ok);
        wait_gen(hc + 2, 2);
        gen_en = 0;
        wait_idle();

        // Shortened 16-BCLK frame, then a normal frame
        push_pair(16'hFFFF, 16'h8001, 20, ok);
        hc = half_cnt;
        half_len = 8;
        gen_en = 1;
        wait_gen(hc + 1, 2);
        gen_en = 0;
        wait_idle();
        push_pair(16'h5A5A, 16'hA5A5, 20, ok);
        half_len = 32;
        gen_en = 1;
        wait_gen(hc + 3, 2);
        gen_en = 0;
        wait_idle();
        check("final_level", fifo_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/gb_i2s_dac_tx.md
Name: gb_i2s_dac_tx

Overview:
- Downstream audio stage between the Game Boy APU sample output and the codec pins AUD_DACDAT, AUD_BCLK and AUD_DACLRCK.
- Buffers stereo sample pairs in a small FIFO.
- Serialises them in I2S format (MSB first, one-BCLK delay after each LRCK edge) against the bit and word clocks driven by the codec.
- All logic runs on the 50 MHz system clock; the codec clocks are oversampled, not used as clocks.

Parameters:
- DATA_WIDTH, 16, bits per channel sample.
- FIFO_DEPTH, 8, stereo pairs buffered; must be a power of 2 and at least 2.

Ports:
- clk  in  1  50 MHz system clock
- reset  in  1  synchronous, active-high reset
- sample_left  in  DATA_WIDTH  left sample, two's complement
- sample_right  in  DATA_WIDTH  right sample, two's complement
- sample_valid  in  1  pair offered
- sample_ready  out  1  FIFO can accept a pair
- aud_bclk  in  1  codec bit clock, asynchronous, at most 3.2 MHz
- aud_daclrck  in  1  codec word clock, asynchronous; low = left, high = right
- aud_dacdat  out  1  serial DAC data
- fifo_level  out  $clog2(FIFO_DEPTH)+1  stored pairs
- underrun  out  1  one-cycle pulse when a left frame starts with the FIFO empty

Behaviour:
- Reset: one clock; reset is synchronous and active-high. While reset is high and on the cycle it is sampled:
  - FIFO emptied, fifo_level=0
  - sample_ready=0, aud_dacdat=0, underrun=0
  - shift register, bit counter and hold registers cleared
  - synchronisers cleared; state=SYNC_WAIT
  - Reset asserted mid-word aborts the word immediately.
- sample_ready = !full && !reset, registered; it is 1 the first cycle after reset deasserts.
- Input synchronisation: aud_bclk and aud_daclrck each pass through two flops, plus a third flop for edge detection.
  - bclk_fall = prev & !cur.
  - lr_fall and lr_rise are detected the same way.
  - Latency from pin to detected edge is 3 clk.
- FIFO write: when sample_valid && sample_ready, {left,right} is written.
  - Data is readable no earlier than the next cycle.
  - A write and a read in the same cycle leave fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine:
  - SYNC_WAIT: ignore bclk and lr_rise; on lr_fall go to LEFT.
  - LEFT: on lr_rise go to RIGHT.
  - RIGHT: on lr_fall go to LEFT.
- Load on lr_fall (entering or re-entering LEFT):
  - If the FIFO is not empty, pop a pair into hold_l/hold_r.
  - Otherwise set hold_l=hold_r=0 and pulse underrun for 1 cycle.
  - The shift register loads the new left value in the same cycle. The popped value is used directly, not via hold_l.
  - bit_cnt is set to DATA_WIDTH.
- Load on lr_rise (entering RIGHT): shift register loads hold_r; bit_cnt is set to DATA_WIDTH.
- Shifting, on bclk_fall in LEFT or RIGHT with no load in the same cycle:
  - If bit_cnt>0: aud_dacdat is driven from shreg[MSB], shreg shifts left, bit_cnt decrements.
  - Else aud_dacdat=0.
- A bclk_fall in the same cycle as an LR edge performs the load only. This gives the I2S one-bit delay: the MSB appears on the next bclk_fall.
- Half-frame shorter than DATA_WIDTH+1 BCLKs: the word is truncated at the next LR edge and the new word loads normally.
- Half-frame longer: pad bits are 0.
- aud_dacdat changes only on bclk_fall cycles or on reset.
- No pop occurs on lr_rise. Exactly one pop happens per stereo frame, at the left start.

Test Plan:
- Reset, then drive BCLK=3.125 MHz (16 clk period) and LRCK=BCLK/64 with the first LR edge falling. Push L=16'hA5C3, R=16'h0F0F.
  -> On the left half, the first bclk_fall after the LR edge leaves data 0; the next 16 falls emit 1010010111000011; then 0 until lr_rise. The right half emits 0000111100001111. fifo_level goes 1→0 at lr_fall.
- Hold sample_valid=1 with incrementing pairs and no LRCK edges.
  -> Exactly 8 pairs accepted. fifo_level=8, sample_ready=0. Pair 9 is held by the source and accepted once ready returns.
- FIFO empty at lr_fall.
  -> underrun=1 for exactly 1 clk; both channels emit 16 zeros; fifo_level stays 0.
- With FIFO at level 8, a push is attempted in the same cycle as the pop at lr_fall.
  -> The push is refused because ready=0. fifo_level=7 and ready=1 on the following cycle; the next push is accepted.
- Assert reset for 1 clk at bit 5 of a left word.
  -> aud_dacdat=0 and fifo_level=0 next cycle. No output until the next lr_fall; the intervening lr_rise is ignored in SYNC_WAIT.
- Shortened frame with LRCK=BCLK/16, push 16'hFFFF/16'h8001.
  -> Left emits 7 ones then truncates. Right emits 1000000 (first 7 bits of 16'h8001); no lockup, next frame proceeds normally.
